multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multi-cycle RV32I datapath (lw, sw, R-type, beq). It shares one memory
//  port and one ALU across fetch, address, execute and branch steps.
//  Each instruction is sequenced over 3-5 states, with memory stalls through a ready handshake.
//  Sits beside the register file/ALU; Opcode comes from the registered IR.
// PARAMETERS
//  RET_CNT_W  32  width of retired-instruction counter InstrRetired
// PORTS
//  clk           in   1          single clock, rising edge
//  rst           in   1          asynchronous, active-high reset
//  Opcode        in   7          IR[6:0], stable from DECODE until instruction end
//  ZeroFlag      in   1          ALU zero
//  MemReady      in   1          memory completes request this cycle
//  MemReq        out  1          memory request valid (FETCH, MEMREAD, MEMWRITE)
//  MemWrite      out  1          write request (MEMWRITE only)
//  AdrSrc        out  1          0=PC, 1=Result as memory address
//  IRWrite       out  1          load IR/OldPC
//  PCWrite       out  1          load PC from Result
//  RegWrite      out  1          register file write
//  ALUSrcA       out  2          00=PC, 01=OldPC, 10=rs1
//  ALUSrcB       out  2          00=rs2, 01=imm, 10=const 4
//  ALUOp         out  2          00=add, 01=sub, 10=funct-decoded
//  ResultSrc     out  2          00=ALUOut, 01=Data, 10=ALUResult
//  ImmSrc        out  2          01=sw, 10=beq, else 00 (combinational on Opcode)
//  InstrRetired  out  RET_CNT_W  retired-instruction count
//  Illegal       out  1          sticky unsupported-opcode flag (ILLEGAL_TRAP_EN only, else 0)
// BEHAVIOUR
//  - Reset: state=FETCH; InstrRetired=0; Illegal=0. While rst=1, all strobes, MemReq and AdrSrc are 0.
//  - First cycle after deassert is FETCH.
//  - Reset asserted mid-instruction aborts it immediately, with no partial PC or register write.
//  - States and outputs (unlisted strobes 0):
//    FETCH:    MemReq, AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10.
//              IRWrite=PCWrite=MemReady. Stay while !MemReady, else ->DECODE.
//    DECODE:   A=01, B=01, ALUOp=00 (branch target into ALUOut).
//              lw/sw->MEMADR; 0110011->EXECR; 1100011->BEQ; other->see CONFIGURATION.
//    MEMADR:   A=10, B=01, ALUOp=00. lw->MEMREAD, sw->MEMWRITE.
//    MEMREAD:  MemReq, AdrSrc=1, ResultSrc=00. Stay while !MemReady, else ->MEMWB.
//    MEMWB:    ResultSrc=01, RegWrite. ->FETCH, retire.
//    MEMWRITE: MemReq, MemWrite, AdrSrc=1, ResultSrc=00. Stay while !MemReady.
//              On MemReady ->FETCH, retire.
//    EXECR:    A=10, B=00, ALUOp=10. ->ALUWB.
//    ALUWB:    ResultSrc=00, RegWrite. ->FETCH, retire.
//    BEQ:      A=10, B=00, ALUOp=01, ResultSrc=00, PCWrite=ZeroFlag. ->FETCH, retire.
//  - Outputs are a Moore decode of state (plus MemReady/ZeroFlag gating as listed); state is registered.
//  - Latency in cycles, zero-wait memory: lw 5, sw 4, R 4, beq 3.
//    Each MemReady=0 cycle adds 1 cycle; a stalled state holds every output constant.
//  - InstrRetired: +1 on the retire cycle; wraps 2^RET_CNT_W-1 -> 0.
//  - MemReady outside FETCH/MEMREAD/MEMWRITE is ignored.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unsupported opcode in DECODE -> TRAP.
//    TRAP: all strobes 0, Illegal=1, no retire; held until reset.
//  ILLEGAL_TRAP_EN undefined: unsupported opcode in DECODE -> FETCH (NOP).
//    No retire; Illegal tied 0; no TRAP state.
// TESTING
//  - Reset: rst=1 mid-MEMREAD -> state FETCH, all strobes 0, InstrRetired=0; after release FETCH asserts MemReq.
//  - R-type 0110011, MemReady=1 -> FETCH,DECODE,EXECR,ALUWB; one RegWrite pulse; InstrRetired +1 after 4 cycles.
//  - lw 0000011, MemReady low 2 cycles in MEMREAD -> 7 cycles total, RegWrite once, ResultSrc=01 in MEMWB.
//  - beq 1100011 with ZeroFlag=1 -> PCWrite in BEQ; with ZeroFlag=0 -> no PCWrite; 3 cycles each.
//  - sw 0100011, MemReady=0 in FETCH 3 cycles -> IRWrite/PCWrite only on ready cycle; MemWrite held through MEMWRITE.
//  - Opcode 1111111 -> TRAP, Illegal=1 until rst (EN); or back to FETCH, count unchanged (no EN).
//  - RET_CNT_W=4: 16 retires -> InstrRetired wraps 15->0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multi-cycle RV32I datapath (lw, sw, R-type, beq) sharing one memory port and ALU.
// Define ILLEGAL_TRAP_EN to trap unsupported opcodes into a sticky TRAP state; otherwise they decode as NOPs.
module multicycle_controller #(
    parameter int RET_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           Opcode,
    input  logic                 ZeroFlag,
    input  logic                 MemReady,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [RET_CNT_W-1:0] InstrRetired,
    output logic                 Illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_ALUWB,
        S_BEQ
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic                   retire;
    logic [RET_CNT_W-1:0]   ret_cnt_q;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWRITE: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECR:    state_d = S_ALUWB;
            S_ALUWB, S_BEQ: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ret_cnt_q <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (retire) ret_cnt_q <= ret_cnt_q + RET_CNT_W'(1);
`ifdef ILLEGAL_TRAP_EN
            if (state_d == S_TRAP) illegal_q <= 1'b1;
`endif
        end
    end

    assign InstrRetired = ret_cnt_q;

    // Moore decode; everything forced low while reset is held so no half-finished write escapes.
    always_comb begin
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ResultSrc = 2'b00;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    MemReq    = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = MemReady;
                    PCWrite   = MemReady;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    MemReq   = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                S_ALUWB:    RegWrite = 1'b1;
                S_BEQ: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b01;
                    PCWrite = ZeroFlag;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (Opcode)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule
